// File: rtl/dist_fifo32.sv
// ---------------------------------------------------------------------------
// dist_fifo32 : 32-deep LUT-RAM FIFO with registered FWFT output stage.
// Optional DIST_FIFO32_LEVEL_EN adds registered O_LEVEL occupancy port.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dist_fifo32 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_WE,
  input  logic [WIDTH-1:0] I_DATA,
  output logic             O_FULL,
  output logic             O_VALID,
  output logic [WIDTH-1:0] O_DATA,
  input  logic             O_READY
`ifdef DIST_FIFO32_LEVEL_EN
  ,output logic [5:0]      O_LEVEL
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY   = 1'b0,
    ST_FULLREG = 1'b1
  } out_state_t;

  logic [WIDTH-1:0] mem_q [32];
  logic [4:0]       wr_ptr_q, wr_ptr_d;
  logic [4:0]       rd_ptr_q, rd_ptr_d;
  logic [5:0]       ram_cnt_q, ram_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  out_state_t       state_q, state_d;
  logic             wr_acc;
  logic             load;

  assign O_FULL  = (ram_cnt_q == 6'd32);
  assign O_VALID = (state_q == ST_FULLREG);
  assign O_DATA  = data_q;

  // Full is judged on registered count only: a same-cycle pop never frees a slot for a write.
  assign wr_acc = I_WE && !O_FULL;
  assign load   = (ram_cnt_q != 6'd0) && (!O_VALID || O_READY);

  always_ff @(posedge CLK) begin
    if (!RST && wr_acc) begin
      mem_q[wr_ptr_q] <= I_DATA;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q + {5'd0, wr_acc} - {5'd0, load};
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 5'd1;
    end
    if (load) begin
      data_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 5'd1;
    end
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULLREG;
        end
      end
      ST_FULLREG: begin
        if (O_READY && !load) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      wr_ptr_q  <= 5'd0;
      rd_ptr_q  <= 5'd0;
      ram_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

`ifdef DIST_FIFO32_LEVEL_EN
  logic [5:0] level_q;
  logic [5:0] level_d;

  assign level_d = ram_cnt_d + {5'd0, (state_d == ST_FULLREG)};
  assign O_LEVEL = level_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_q <= 6'd0;
    end else begin
      level_q <= level_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dist_fifo32.sv
// ---------------------------------------------------------------------------
// tb_dist_fifo32 : directed and random self-checking bench for dist_fifo32.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dist_fifo32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_we = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_ready = 1'b0;
  logic       o_full;
  logic       o_valid;
  logic [7:0] o_data;
`ifdef DIST_FIFO32_LEVEL_EN
  logic [5:0] o_level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: RAM contents as a queue plus the output register.
  logic [7:0] mq [$];
  logic       mv;
  logic [7:0] md;

  always #5 clk = ~clk;

  dist_fifo32 #(.WIDTH(8)) dut (
    .CLK     (clk),
    .RST     (rst),
    .I_WE    (i_we),
    .I_DATA  (i_data),
    .O_FULL  (o_full),
    .O_VALID (o_valid),
    .O_DATA  (o_data),
    .O_READY (o_ready)
`ifdef DIST_FIFO32_LEVEL_EN
    ,.O_LEVEL(o_level)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("valid", {63'd0, o_valid}, {63'd0, mv});
    if (mv) check("data", {56'd0, o_data}, {56'd0, md});
    check("full", {63'd0, o_full}, {63'd0, (mq.size() == 32)});
`ifdef DIST_FIFO32_LEVEL_EN
    check("level", {58'd0, o_level}, 64'(mq.size() + int'(mv)));
`endif
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cyc(input logic we, input logic [7:0] d, input logic rdy);
    logic wacc, ld;
    i_we = we; i_data = d; o_ready = rdy;
    wacc = we && (mq.size() < 32);
    ld   = (mq.size() != 0) && (!mv || rdy);
    if (ld) begin
      md = mq.pop_front();
      mv = 1'b1;
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    if (wacc) mq.push_back(d);
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_we = 1'b1; i_data = 8'hCC; o_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_we = 1'b0; o_ready = 1'b0;
    mq.delete();
    mv = 1'b0;
    md = 8'h00;
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_full",  {63'd0, o_full},  64'd0);
    check("rst_data",  {56'd0, o_data},  64'd0);
`ifdef DIST_FIFO32_LEVEL_EN
    check("rst_level", {58'd0, o_level}, 64'd0);
`endif
  endtask

  initial begin
    int k;
    mv = 1'b0;
    md = 8'h00;
    @(posedge clk); #1;

    // 1: single word, one-cycle latency to output
    do_reset();
    cyc(1'b1, 8'h11, 1'b0);
    check("t1_v_e1", {63'd0, o_valid}, 64'd0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t1_v_e2", {63'd0, o_valid}, 64'd1);
    check("t1_data", {56'd0, o_data}, 64'h11);
    check("t1_full", {63'd0, o_full}, 64'd0);

    // 2: fill to 33, overflow write dropped, ordered drain
    do_reset();
    for (int i = 0; i < 33; i++) cyc(1'b1, 8'(i), 1'b0);
    check("t2_full", {63'd0, o_full}, 64'd1);
    cyc(1'b1, 8'hFF, 1'b0);
    check("t2_full_hold", {63'd0, o_full}, 64'd1);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) begin
        check("t2_order", {56'd0, o_data}, 64'(k));
        k++;
      end
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("t2_count", 64'(k), 64'd33);

    // 3: streaming at one word per cycle through pointer wrap
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 8'(i), 1'b1);
      if (i >= 1) begin
        check("t3_valid", {63'd0, o_valid}, 64'd1);
        check("t3_data", {56'd0, o_data}, 64'(i - 1));
      end
      check("t3_full", {63'd0, o_full}, 64'd0);
    end
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_last", {56'd0, o_data}, 64'd99);

    // 4: full with simultaneous write and pop
    do_reset();
    for (int i = 0; i < 33; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hEE, 1'b1);
    check("t4_full", {63'd0, o_full}, 64'd0);
    check("t4_data", {56'd0, o_data}, 64'd1);
`ifdef DIST_FIFO32_LEVEL_EN
    check("t4_level", {58'd0, o_level}, 64'd32);
`endif
    k = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (o_valid) begin
        k++;
        check("t4_order", {56'd0, o_data}, 64'(k));
      end
    end
    check("t4_count", 64'(k), 64'd32);

    // 5: random traffic against the model
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // 6: reset with content held, then fresh word emerges first
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    do_reset();
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t6_valid", {63'd0, o_valid}, 64'd1);
    check("t6_data", {56'd0, o_data}, 64'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
